// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with debounce and key decode
// Emits one registered pulse per accepted keystroke; no auto-repeat.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val
);

  localparam int SW = $clog2(SCAN_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  state_t        state_q;
  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    row_idx_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          is_num_q;
  logic          is_op_q;
  logic          is_eq_q;
  logic          is_clr_q;
  logic [3:0]    num_val_q;
  logic [1:0]    op_val_q;

  logic [1:0]    low_row_d;
  logic          row_bit_d;
  logic          key_is_num_d;
  logic          key_is_op_d;
  logic          key_is_eq_d;
  logic          key_is_clr_d;
  logic [3:0]    key_num_d;

  // Lowest-index low row wins when several rows read low together.
  always_comb begin
    low_row_d = 2'd3;
    if (!row_sync_q[0])      low_row_d = 2'd0;
    else if (!row_sync_q[1]) low_row_d = 2'd1;
    else if (!row_sync_q[2]) low_row_d = 2'd2;
  end

  assign row_bit_d = row_sync_q[row_idx_q];

  // Column 3 holds the operators; row 3 holds '*', '0', '#'.
  always_comb begin
    key_is_op_d  = (col_idx_q == 2'd3);
    key_is_clr_d = (row_idx_q == 2'd3) && (col_idx_q == 2'd0);
    key_is_eq_d  = (row_idx_q == 2'd3) && (col_idx_q == 2'd2);
    key_is_num_d = !key_is_op_d && !key_is_clr_d && !key_is_eq_d;
    key_num_d    = 4'd0;
    if (row_idx_q != 2'd3) begin
      key_num_d = ({2'b00, row_idx_q} * 4'd3) + {2'b00, col_idx_q} + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      is_num_q   <= 1'b0;
      is_op_q    <= 1'b0;
      is_eq_q    <= 1'b0;
      is_clr_q   <= 1'b0;
      num_val_q  <= 4'd0;
      op_val_q   <= 2'd0;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      is_num_q   <= 1'b0;
      is_op_q    <= 1'b0;
      is_eq_q    <= 1'b0;
      is_clr_q   <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (row_sync_q != 4'hF) begin
              row_idx_q <= low_row_d;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_bit_d) begin
            if (deb_cnt_q == DEB_LAST) begin
              deb_cnt_q <= '0;
              state_q   <= RELEASE;
              is_num_q  <= key_is_num_d;
              is_op_q   <= key_is_op_d;
              is_eq_q   <= key_is_eq_d;
              is_clr_q  <= key_is_clr_d;
              if (key_is_num_d) num_val_q <= key_num_d;
              if (key_is_op_d)  op_val_q  <= row_idx_q;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            deb_cnt_q <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            state_q   <= SCAN;
          end
        end
        RELEASE: begin
          // Any low cycle on the latched row restarts the release window.
          if (row_bit_d) begin
            if (deb_cnt_q == DEB_LAST) begin
              deb_cnt_q <= '0;
              col_idx_q <= col_idx_q + 2'd1;
              state_q   <= SCAN;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end else begin
            deb_cnt_q <= '0;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col_out = ~(4'b0001 << col_idx_q);
  assign is_num  = is_num_q;
  assign is_op   = is_op_q;
  assign is_eq   = is_eq_q;
  assign is_clr  = is_clr_q;
  assign num_val = num_val_q;
  assign op_val  = op_val_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with keypad physics model
// Directed scenarios plus randomized key presses against a behavioural reference.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       is_num, is_op, is_eq, is_clr;
  logic [3:0] num_val;
  logic [1:0] op_val;
  logic [15:0] keys = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_num  = 0;
  int cnt_op   = 0;
  int cnt_eq   = 0;
  int cnt_clr  = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .col_out(col_out),
    .is_num (is_num),
    .is_op  (is_op),
    .is_eq  (is_eq),
    .is_clr (is_clr),
    .num_val(num_val),
    .op_val (op_val)
  );

  // Keypad physics: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (is_num === 1'b1) cnt_num <= cnt_num + 1;
    if (is_op === 1'b1)  cnt_op  <= cnt_op + 1;
    if (is_eq === 1'b1)  cnt_eq  <= cnt_eq + 1;
    if (is_clr === 1'b1) cnt_clr <= cnt_clr + 1;
  end

  // Reference model: what the DUT must show after each clock edge.
  string      keymap = "123A456B789C*0#D";
  logic [3:0] row_smp;
  logic       rst_smp = 1'b1;
  logic [3:0] m_s1, m_s2;
  int         m_col, m_dwell, m_mode, m_row, m_run;
  logic       m_num, m_op, m_eq, m_clr;
  logic [3:0] m_nv;
  logic [1:0] m_ov;
  bit         started = 1'b0;

  always @(posedge clk) begin
    row_smp <= row_in;
    rst_smp <= rst;
  end

  always @(negedge clk) begin
    logic [3:0] rs;
    logic [7:0] ch;
    logic [3:0] ecol;
    m_num = 1'b0; m_op = 1'b0; m_eq = 1'b0; m_clr = 1'b0;
    if (rst_smp) begin
      started = 1'b1;
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_col = 0; m_dwell = 0; m_mode = 0; m_row = 0; m_run = 0;
      m_nv = 4'd0; m_ov = 2'd0;
    end else if (started) begin
      rs = m_s2; m_s2 = m_s1; m_s1 = row_smp;
      case (m_mode)
        0: begin
          if (m_dwell == SC - 1) begin
            m_dwell = 0;
            if (rs != 4'hF) begin
              for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
              m_mode = 1; m_run = 0;
            end else m_col = (m_col + 1) % 4;
          end else m_dwell++;
        end
        1: begin
          if (!rs[m_row]) begin
            m_run++;
            if (m_run == DB) begin
              ch = keymap[m_row*4+m_col];
              if (ch >= 8'h30 && ch <= 8'h39) begin m_num = 1'b1; m_nv = 4'(ch - 8'h30); end
              else if (ch >= 8'h41 && ch <= 8'h44) begin m_op = 1'b1; m_ov = 2'(ch - 8'h41); end
              else if (ch == 8'h23) m_eq = 1'b1;
              else m_clr = 1'b1;
              m_mode = 2; m_run = 0;
            end
          end else begin
            m_mode = 0; m_run = 0; m_col = (m_col + 1) % 4;
          end
        end
        default: begin
          if (!rs[m_row]) m_run = 0;
          else begin
            m_run++;
            if (m_run == DB) begin
              m_mode = 0; m_run = 0; m_col = (m_col + 1) % 4;
            end
          end
        end
      endcase
    end
    if (started) begin
      ecol = 4'hF;
      ecol[m_col] = 1'b0;
      check("cycle", {col_out, is_num, is_op, is_eq, is_clr, num_val, op_val},
            {ecol, m_num, m_op, m_eq, m_clr, m_nv, m_ov});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    keys[r*4+c] = 1'b0;
  endtask

  function automatic int pcount(input int which);
    case (which)
      0: return cnt_num;
      1: return cnt_op;
      2: return cnt_eq;
      default: return cnt_clr;
    endcase
  endfunction

  task automatic wait_more(input int which, input int base, input string name);
    int k = 0;
    while (pcount(which) <= base && k < 400) begin @(negedge clk); k++; end
    check(name, (k < 400), 1);
  endtask

  task automatic wait_col(input logic [3:0] v, input string name);
    int k = 0;
    while (col_out == v && k < 200) begin @(negedge clk); k++; end
    while (col_out != v && k < 200) begin @(negedge clk); k++; end
    check(name, (k < 200), 1);
  endtask

  task automatic wait_leave(input logic [3:0] v, input string name);
    int k = 0;
    while (col_out == v && k < 200) begin @(negedge clk); k++; end
    check(name, (k < 200), 1);
  endtask

  logic [3:0] walk [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int b0;
    int k1;
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_pulses", {is_num, is_op, is_eq, is_clr}, 4'b0000);
    check("rst_num", num_val, 4'd0);
    check("rst_op", op_val, 2'd0);
    rst = 1'b0;
    tick(2);
    check("walk_c0", col_out, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      tick(4);
      check("walk", col_out, walk[i]);
    end

    b0 = cnt_num;
    press(1, 1);
    wait_more(0, b0, "five_seen");
    tick(20);
    check("five_cnt", cnt_num - b0, 1);
    check("five_val", num_val, 4'd5);
    check("five_hold_col", col_out, 4'b1101);
    unpress(1, 1);
    wait_leave(4'b1101, "five_leave");
    check("five_next_col", col_out, 4'b1011);

    b0 = cnt_op;
    press(2, 3);
    wait_more(1, b0, "c_seen");
    tick(100);
    check("c_cnt", cnt_op - b0, 1);
    check("c_val", op_val, 2'b10);
    unpress(2, 3);
    tick(40);

    b0 = cnt_eq;
    wait_col(4'b1011, "bounce_col");
    press(3, 2);
    tick(5);
    unpress(3, 2);
    wait_leave(4'b1011, "bounce_leave");
    check("bounce_next_col", col_out, 4'b0111);
    tick(10);
    check("bounce_cnt", cnt_eq - b0, 0);
    press(3, 2);
    wait_more(2, b0, "eq_seen");
    tick(10);
    unpress(3, 2);
    tick(30);
    check("eq_cnt", cnt_eq - b0, 1);

    b0 = cnt_num;
    press(0, 0);
    wait_more(0, b0, "one_seen");
    check("one_val", num_val, 4'd1);
    press(2, 2);
    tick(30);
    check("one_only", cnt_num - b0, 1);
    unpress(0, 0);
    wait_more(0, b0 + 1, "nine_seen");
    check("nine_val", num_val, 4'd9);
    tick(10);
    check("nine_cnt", cnt_num - b0, 2);
    unpress(2, 2);
    tick(40);

    b0 = cnt_clr;
    wait_col(4'b1110, "clr_col");
    press(3, 0);
    tick(8);
    rst = 1'b1;
    unpress(3, 0);
    tick(1);
    check("clr_rst_col", col_out, 4'b1110);
    check("clr_rst_num", num_val, 4'd0);
    check("clr_rst_op", op_val, 2'd0);
    rst = 1'b0;
    tick(30);
    check("clr_cnt", cnt_clr - b0, 0);

    for (int i = 0; i < 80; i++) begin
      k1 = $urandom_range(0, 15);
      keys[k1] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      tick($urandom_range(1, 60));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      keys = '0;
      tick($urandom_range(10, 50));
    end
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
